// File: rtl/zigzag_pkg.sv
// Shared types and defaults for the rail-fence encryptor.
package zigzag_pkg;

  localparam int MAX_NOF_CHARS_DEF = 50;
  localparam logic [7:0] TOKEN_DEF = 8'hFA;

  typedef enum logic {
    COLLECT,
    EMIT
  } state_t;

  function automatic int idx_w(input int n);
    return $clog2(2 * n) + 1;
  endfunction

  localparam int IDX_W = idx_w(MAX_NOF_CHARS_DEF);

endpackage

// File: rtl/zigzag_index_gen.sv
// Rail/step counters producing the zigzag read order.
module zigzag_index_gen
  import zigzag_pkg::*;
#(
  parameter int IW = IDX_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [IW-1:0] len,
  input  logic [IW-1:0] k_r,
  output logic [IW-1:0] idx,
  output logic          idx_valid,
  output logic          last
);

  logic          active;
  logic          up;
  logic [IW-1:0] rail;
  logic [IW-1:0] full;
  logic [IW-1:0] step;
  logic [IW-1:0] nidx;
  logic [IW-1:0] nrail;
  logic [IW-1:0] next_idx;
  logic [IW-1:0] next_rail;
  logic          next_up;
  logic          done;

  always_comb begin
    full = (k_r - 1'b1) << 1;
    step = up ? (rail << 1) : ((k_r - 1'b1 - rail) << 1);
    // outer rails take the whole period; a single rail walks by one
    if (step == '0) step = full;
    if (step == '0) step = IW'(1);
    nidx      = idx + step;
    nrail     = rail + 1'b1;
    next_idx  = idx;
    next_rail = rail;
    next_up   = up;
    done      = 1'b0;
    if (nidx < len) begin
      next_idx = nidx;
      next_up  = ~up;
    end else if (nrail < k_r && nrail < len) begin
      next_idx  = nrail;
      next_rail = nrail;
      next_up   = 1'b0;
    end else begin
      done = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      up     <= 1'b0;
      rail   <= '0;
      idx    <= '0;
    end else if (start) begin
      active <= 1'b1;
      up     <= 1'b0;
      rail   <= '0;
      idx    <= '0;
    end else if (active) begin
      if (done) begin
        active <= 1'b0;
      end else begin
        up   <= next_up;
        rail <= next_rail;
        idx  <= next_idx;
      end
    end
  end

  assign idx_valid = active;
  assign last      = active && done;

endmodule

// File: rtl/zigzag_encryption.sv
// Buffers a plaintext message, then emits it in rail-fence order.
module zigzag_encryption
  import zigzag_pkg::*;
#(
  parameter int                  D_WIDTH       = 8,
  parameter int                  KEY_WIDTH     = 8,
  parameter int                  MAX_NOF_CHARS = MAX_NOF_CHARS_DEF,
  parameter logic [D_WIDTH-1:0]  START_ENCRYPTION_TOKEN = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o
);

  localparam int IW = idx_w(MAX_NOF_CHARS);
  localparam int AW = $clog2(MAX_NOF_CHARS);
  localparam logic [IW-1:0] MAX_L = IW'(MAX_NOF_CHARS);

  state_t state;
  state_t nstate;

  logic [IW-1:0]      len;
  logic [IW-1:0]      k_r;
  logic [IW-1:0]      k_eff;
  logic [IW-1:0]      idx;
  logic [AW-1:0]      wr_addr;
  logic [AW-1:0]      rd_addr;
  logic               idx_valid;
  logic               last;
  logic               tok;
  logic               store;
  logic               start;
  logic [D_WIDTH-1:0] mem [MAX_NOF_CHARS];

  always_comb begin
    tok   = valid_i && (data_i == START_ENCRYPTION_TOKEN);
    store = (state == COLLECT) && valid_i && !tok && (len < MAX_L);
    start = (state == COLLECT) && tok && (len != '0);
    wr_addr = AW'(len);
    rd_addr = AW'(idx);
  end

  always_comb begin
    if (key == '0)
      k_eff = IW'(1);
    else if (32'(key) > 32'(MAX_NOF_CHARS))
      k_eff = MAX_L;
    else
      k_eff = IW'(key);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      COLLECT: if (start) nstate = EMIT;
      EMIT:    if (last)  nstate = COLLECT;
      default: nstate = COLLECT;
    endcase
  end

  always_comb begin
    busy = (state == EMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len <= '0;
      k_r <= IW'(1);
    end else begin
      if (state == EMIT && last) len <= '0;
      else if (store)            len <= len + 1'b1;
      if (state == COLLECT && tok) k_r <= k_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem[wr_addr] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      data_o  <= idx_valid ? mem[rd_addr] : '0;
      valid_o <= idx_valid;
    end
  end

  zigzag_index_gen #(
    .IW(IW)
  ) u_index_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .k_r      (k_r),
    .idx      (idx),
    .idx_valid(idx_valid),
    .last     (last)
  );

endmodule

// File: tb/tb_zigzag_encryption.sv
// Directed bench for the rail-fence encryptor.
module tb_zigzag_encryption;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] key;
  logic       busy;
  logic [7:0] data_o;
  logic       valid_o;

  int checks;
  int failures;
  int skip_first;

  zigzag_encryption dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (data_i),
    .valid_i(valid_i),
    .key    (key),
    .busy   (busy),
    .data_o (data_o),
    .valid_o(valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_char(input byte c);
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = c;
  endtask

  // noise: drive junk and tokens while busy; chain: first char of next msg
  task automatic encrypt(input string tag, input string pt,
                         input logic [7:0] k, input string exp,
                         input bit noise, input string chain);
    byte got[$];
    int  l;
    int  bad_busy;
    int  bad_valid;
    int  bad_zero;
    l = exp.len();
    bad_busy = 0;
    bad_valid = 0;
    bad_zero = 0;
    for (int i = skip_first; i < pt.len(); i++) send_char(pt[i]);
    skip_first = 0;
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = 8'hFA;
    key     = k;
    for (int i = 1; i <= l + 2; i++) begin
      @(negedge clk);
      if (busy !== (i <= l)) bad_busy++;
      if (valid_o !== (i >= 2 && i <= l + 1)) bad_valid++;
      if (valid_o === 1'b1) got.push_back(data_o);
      else if (data_o !== 8'h00) bad_zero++;
      if (noise && i <= l) begin
        valid_i = 1'b1;
        data_i  = (i % 2 == 1) ? 8'h5A : 8'hFA;
        key     = 8'd2;
      end else if (i == l + 1 && chain.len() > 0) begin
        valid_i = 1'b1;
        data_i  = chain[0];
        skip_first = 1;
      end else begin
        valid_i = 1'b0;
        data_i  = 8'h00;
      end
    end
    check({tag, "_busy"}, bad_busy, 0);
    check({tag, "_valid"}, bad_valid, 0);
    check({tag, "_idle0"}, bad_zero, 0);
    check({tag, "_count"}, got.size(), l);
    for (int i = 0; i < l && i < got.size(); i++)
      check($sformatf("%s_ch%0d", tag, i), got[i], exp[i]);
  endtask

  string long_pt;
  string long_exp;

  initial begin
    checks = 0;
    failures = 0;
    skip_first = 0;
    rst_n = 1'b0;
    data_i = 8'h00;
    valid_i = 1'b0;
    key = 8'd0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    encrypt("k3", "HELLOWORLD", 8'd3, "HOLELWRDLO", 0, "");
    encrypt("k2", "HELLOWORLD", 8'd2, "HLOOLELWRD", 0, "");
    encrypt("k1", "HELLOWORLD", 8'd1, "HELLOWORLD", 0, "");
    encrypt("k0", "HELLOWORLD", 8'd0, "HELLOWORLD", 0, "");
    encrypt("kbig", "HELLOWORLD", 8'd200, "HELLOWORLD", 0, "");
    encrypt("abc", "ABC", 8'd5, "ABC", 0, "");
    encrypt("empty", "", 8'd3, "", 0, "");

    long_pt = "";
    long_exp = "";
    for (int i = 0; i < 52; i++)
      long_pt = $sformatf("%s%c", long_pt, 8'h41 + (i % 26));
    for (int i = 0; i < 50; i += 2)
      long_exp = $sformatf("%s%c", long_exp, long_pt[i]);
    for (int i = 1; i < 50; i += 2)
      long_exp = $sformatf("%s%c", long_exp, long_pt[i]);
    encrypt("sat", long_pt, 8'd2, long_exp, 0, "");

    encrypt("noise", "HELLOWORLD", 8'd3, "HOLELWRDLO", 1, "ABCDEF");
    encrypt("chain", "ABCDEF", 8'd2, "ACEBDF", 0, "");

    for (int i = 0; i < 10; i++) send_char(8'h30 + 8'(i));
    @(negedge clk);
    data_i = 8'hFA;
    key = 8'd3;
    repeat (4) @(negedge clk);
    valid_i = 1'b0;
    check("pre_rst_valid", valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_data", data_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    encrypt("post", "ABCDEF", 8'd2, "ACEBDF", 0, "");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
